// File: rtl/hex_display_ctrl.sv
// Sequential signed-binary-to-BCD controller for a row of seven-segment displays.
// Double-dabble conversion, one bit per clock; outputs update only on the done edge.
module hex_display_ctrl #(
    parameter int DATA_W     = 20,
    parameter int NUM_DIGITS = 6,
    parameter int BLANK_LZ   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       value,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dig_neg,
    output logic [NUM_DIGITS-1:0]   dig_blank,
    output logic                    ovf
);

    // Decimal digit count of 2^DATA_W-1 (floor(DATA_W*log10(2))+1).
    localparam int BCD_DIGITS = (DATA_W * 301) / 1000 + 1;
    localparam int ACC_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
    localparam int ACC_W      = 4 * ACC_DIGITS;
    localparam int CNT_W      = $clog2(DATA_W + 1);
    localparam logic [NUM_DIGITS-1:0] BLANK_RST = ~NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [ACC_W-1:0]   bcd_r;
    logic [DATA_W-1:0]  mag_r;
    logic               sign_r;

    logic [ACC_W-1:0]        bcd_adj_s;
    logic [ACC_W-1:0]        bcd_next_s;
    logic [DATA_W-1:0]       mag_next_s;
    logic                    ovf_s;
    logic [4*NUM_DIGITS-1:0] digits_s;
    logic [NUM_DIGITS-1:0]   blank_s;
    logic [NUM_DIGITS-1:0]   neg_s;
    logic                    zero_above_s;
    logic                    neg_found_s;

    function automatic logic [ACC_W-1:0] bcd_adjust(input logic [ACC_W-1:0] bcd);
        logic [ACC_W-1:0] res;
        res = bcd;
        for (int i = 0; i < ACC_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return res;
    endfunction

    // One double-dabble step: add-3 correction, then shift the combined register left.
    always_comb begin
        bcd_adj_s = bcd_adjust(bcd_r);
        {bcd_next_s, mag_next_s} = {bcd_adj_s, mag_r} << 1;
    end

    // Display image derived from the finished accumulator: saturation, blanking, sign placement.
    always_comb begin
        ovf_s = 1'b0;
        for (int i = NUM_DIGITS; i < ACC_DIGITS; i++) begin
            ovf_s = ovf_s | (bcd_r[4*i +: 4] != 4'd0);
        end
        if (ovf_s) begin
            digits_s = {NUM_DIGITS{4'h9}};
        end else begin
            digits_s = bcd_r[4*NUM_DIGITS-1:0];
        end
        blank_s      = '0;
        zero_above_s = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above_s = zero_above_s & (digits_s[4*i +: 4] == 4'd0);
            blank_s[i]   = zero_above_s & (BLANK_LZ != 0);
        end
        // Minus sign goes on the most significant digit that is still lit.
        neg_s       = '0;
        neg_found_s = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (sign_r && !neg_found_s && !blank_s[i]) begin
                neg_s[i]    = 1'b1;
                neg_found_s = 1'b1;
            end else begin
                neg_s[i]    = 1'b0;
            end
        end
    end

    // Conversion FSM and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            bcd_r     <= '0;
            mag_r     <= '0;
            sign_r    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            digits    <= '0;
            dig_neg   <= '0;
            dig_blank <= BLANK_RST;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        sign_r  <= value[DATA_W-1];
                        mag_r   <= value[DATA_W-1] ? (~value + DATA_W'(1)) : value;
                        bcd_r   <= '0;
                        cnt_r   <= CNT_W'(DATA_W);
                        state_r <= ST_SHIFT;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    bcd_r <= bcd_next_s;
                    mag_r <= mag_next_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= ST_FINISH;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_FINISH: begin
                    digits    <= digits_s;
                    dig_blank <= blank_s;
                    dig_neg   <= neg_s;
                    ovf       <= ovf_s;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: a 20-bit and a 24-bit instance checked every cycle against
// an arithmetic model, plus hand-computed expectations for the directed vectors.
module tb_hex_display_ctrl;

    typedef struct packed {
        logic [23:0] dig;
        logic [5:0]  blank;
        logic [5:0]  neg;
        logic        ovf;
    } res_t;

    localparam res_t RST_OUT = '{dig: 24'h0, blank: 6'b111110, neg: 6'b0, ovf: 1'b0};

    logic        clk;
    logic        rst_n;
    logic        start_a  [2];
    logic [23:0] value_a  [2];
    logic        busy_a   [2];
    logic        done_a   [2];
    logic        ovf_a    [2];
    logic [23:0] digits_a [2];
    logic [5:0]  neg_a    [2];
    logic [5:0]  blank_a  [2];

    int n_checks = 0;
    int n_errors = 0;

    res_t m_out  [2];
    res_t m_pend [2];
    logic m_busy [2];
    logic m_done [2];
    int   m_left [2];

    hex_display_ctrl #(.DATA_W(20), .NUM_DIGITS(6), .BLANK_LZ(1)) dut20 (
        .clk(clk), .rst_n(rst_n), .value(value_a[0][19:0]), .start(start_a[0]),
        .busy(busy_a[0]), .done(done_a[0]), .digits(digits_a[0]),
        .dig_neg(neg_a[0]), .dig_blank(blank_a[0]), .ovf(ovf_a[0])
    );

    hex_display_ctrl #(.DATA_W(24), .NUM_DIGITS(6), .BLANK_LZ(1)) dut24 (
        .clk(clk), .rst_n(rst_n), .value(value_a[1]), .start(start_a[1]),
        .busy(busy_a[1]), .done(done_a[1]), .digits(digits_a[1]),
        .dig_neg(neg_a[1]), .dig_blank(blank_a[1]), .ovf(ovf_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // What a 6-digit display must show for a signed value, by plain decimal arithmetic.
    function automatic res_t model(input longint v);
        longint mag;
        longint t;
        int     nd;
        res_t   r;
        mag   = (v < 0) ? -v : v;
        r.ovf = (mag > 64'sd999999);
        if (r.ovf) mag = 64'sd999999;
        t     = mag;
        r.dig = '0;
        for (int i = 0; i < 6; i++) begin
            r.dig[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        nd = 1;
        t  = mag / 10;
        while (t > 0) begin
            nd++;
            t = t / 10;
        end
        r.blank = '0;
        for (int i = 0; i < 6; i++) r.blank[i] = (i >= nd);
        r.neg = '0;
        if (v < 0) r.neg[nd-1] = 1'b1;
        return r;
    endfunction

    // Transaction-level model: a conversion accepted while idle completes DATA_W+1 edges later.
    always @(posedge clk or negedge rst_n) begin
        for (int s = 0; s < 2; s++) begin
            if (!rst_n) begin
                m_out[s]  = RST_OUT;
                m_busy[s] = 1'b0;
                m_done[s] = 1'b0;
                m_left[s] = 0;
            end else begin
                m_done[s] = 1'b0;
                if (m_busy[s]) begin
                    if (m_left[s] == 1) begin
                        m_out[s]  = m_pend[s];
                        m_done[s] = 1'b1;
                        m_busy[s] = 1'b0;
                    end else begin
                        m_left[s]--;
                    end
                end else if (start_a[s]) begin
                    if (s == 0) m_pend[s] = model(longint'($signed(value_a[0][19:0])));
                    else        m_pend[s] = model(longint'($signed(value_a[1])));
                    m_left[s] = (s == 0) ? 21 : 25;
                    m_busy[s] = 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("busy%0d", s),   32'(busy_a[s]),   32'(m_busy[s]));
            chk($sformatf("done%0d", s),   32'(done_a[s]),   32'(m_done[s]));
            chk($sformatf("digits%0d", s), 32'(digits_a[s]), 32'(m_out[s].dig));
            chk($sformatf("blank%0d", s),  32'(blank_a[s]),  32'(m_out[s].blank));
            chk($sformatf("neg%0d", s),    32'(neg_a[s]),    32'(m_out[s].neg));
            chk($sformatf("ovf%0d", s),    32'(ovf_a[s]),    32'(m_out[s].ovf));
        end
    end

    // Starts a conversion now (between negedge and posedge) and returns once done is seen.
    task automatic convert(input int sel, input longint v, output int lat);
        start_a[sel] = 1'b1;
        value_a[sel] = v[23:0];
        @(negedge clk); #1;
        start_a[sel] = 1'b0;
        value_a[sel] = ~value_a[sel];
        lat = 0;
        while (!done_a[sel] && lat < 100) begin
            @(negedge clk); #1;
            lat++;
        end
    endtask

    task automatic expect_out(input int sel, input string name, input logic [23:0] dig,
                              input logic [5:0] blank, input logic [5:0] neg, input logic ov);
        chk({name, "_digits"}, 32'(digits_a[sel]), 32'(dig));
        chk({name, "_blank"},  32'(blank_a[sel]),  32'(blank));
        chk({name, "_neg"},    32'(neg_a[sel]),    32'(neg));
        chk({name, "_ovf"},    32'(ovf_a[sel]),    32'(ov));
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int done_cnt;
        rst_n      = 1'b0;
        start_a[0] = 1'b0;
        start_a[1] = 1'b0;
        value_a[0] = 24'h0;
        value_a[1] = 24'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy_a[0]), 32'd0);
        chk("rst_done", 32'(done_a[0]), 32'd0);
        expect_out(0, "rst", 24'h000000, 6'b111110, 6'b000000, 1'b0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        convert(0, 1234, lat);
        chk("t1_latency", 32'(lat), 32'd21);
        expect_out(0, "t1", 24'h001234, 6'b110000, 6'b000000, 1'b0);
        convert(0, -5, lat);
        expect_out(0, "t2", 24'h000005, 6'b111110, 6'b000001, 1'b0);
        convert(0, 0, lat);
        expect_out(0, "t3_zero", 24'h000000, 6'b111110, 6'b000000, 1'b0);
        convert(0, -524288, lat);
        expect_out(0, "t3_min", 24'h524288, 6'b000000, 6'b100000, 1'b0);
        convert(0, 524287, lat);
        expect_out(0, "t3_max", 24'h524287, 6'b000000, 6'b000000, 1'b0);
        convert(0, -100, lat);
        expect_out(0, "t3_m100", 24'h000100, 6'b111000, 6'b000100, 1'b0);

        // start pulsed mid-conversion must be dropped
        @(negedge clk); #1;
        start_a[0] = 1'b1;
        value_a[0] = 24'd42;
        @(negedge clk); #1;
        start_a[0] = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int j = 0; j < 40; j++) begin
            busy_cnt += int'(busy_a[0]);
            done_cnt += int'(done_a[0]);
            if (j == 4) begin
                start_a[0] = 1'b1;
                value_a[0] = 24'd999999;
            end else begin
                start_a[0] = 1'b0;
            end
            @(negedge clk); #1;
        end
        chk("t4_busy_cycles", 32'(busy_cnt), 32'd21);
        chk("t4_done_count", 32'(done_cnt), 32'd1);
        expect_out(0, "t4", 24'h000042, 6'b111100, 6'b000000, 1'b0);

        // reset in the middle of SHIFT
        start_a[0] = 1'b1;
        value_a[0] = 24'd1234;
        @(negedge clk); #1;
        start_a[0] = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy_a[0]), 32'd0);
        chk("t5_done", 32'(done_a[0]), 32'd0);
        expect_out(0, "t5_rst", 24'h000000, 6'b111110, 6'b000000, 1'b0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        done_cnt = 0;
        for (int j = 0; j < 30; j++) begin
            done_cnt += int'(done_a[0]);
            @(negedge clk); #1;
        end
        chk("t5_no_done", 32'(done_cnt), 32'd0);
        convert(0, 987, lat);
        chk("t5_latency", 32'(lat), 32'd21);
        expect_out(0, "t5_after", 24'h000987, 6'b111000, 6'b000000, 1'b0);

        // 24-bit instance: saturation and back-to-back starts on the done cycle
        convert(1, 1000000, lat);
        chk("t6_latency", 32'(lat), 32'd25);
        expect_out(1, "t6_pos", 24'h999999, 6'b000000, 6'b000000, 1'b1);
        convert(1, -1000000, lat);
        chk("t6_b2b_latency", 32'(lat), 32'd25);
        expect_out(1, "t6_neg", 24'h999999, 6'b000000, 6'b100000, 1'b1);
        convert(1, -8388608, lat);
        expect_out(1, "t6_min", 24'h999999, 6'b000000, 6'b100000, 1'b1);
        convert(1, 999999, lat);
        expect_out(1, "t6_edge", 24'h999999, 6'b000000, 6'b000000, 1'b0);
        convert(1, -1, lat);
        expect_out(1, "t6_m1", 24'h000001, 6'b111110, 6'b000001, 1'b0);

        repeat (5) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
